// File: rtl/button_debounce.sv
// button_debounce: synchronizes and debounces an active-low pushbutton, counts presses,
//   and optionally reports long presses (enable with `define BUTTON_DEBOUNCE_LONGPRESS_EN).
// Latency: press_pulse / release_pulse rise DEBOUNCE_CYCLES+2 clocks after a stable btn_n change.
// Backpressure: none; strobes are single-cycle and not held, so the consumer must sample every clock.
// Ports:
//   clk, rst       single clock; asynchronous active-high reset
//   btn_n          raw button, asynchronous to clk, 0 = pressed
//   clr            synchronous clear of press_count
//   btn_level      debounced level, 1 = pressed
//   press_pulse    one-cycle strobe when a press is accepted
//   release_pulse  one-cycle strobe when a release is accepted
//   long_pulse     one-cycle strobe once a press has been held LONG_CYCLES (0 when feature off)
//   press_count    accepted presses modulo 256
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int LONG_CYCLES     = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic       clr,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } state_t;

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES);

    logic        r_sync1;
    logic        r_sync2;
    logic        w_pressed;
    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        w_press_set;
    logic        w_release_set;
    logic        w_level_nxt;
    logic        r_level;
    logic        r_press;
    logic        r_release;
    logic [7:0]  r_count;

    // Two-flop synchronizer; resets to the released level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = ~r_sync2;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic. The counter only increments while below DB_LAST, so it cannot wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = 16'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_pressed) begin
                    w_state_nxt = ST_PRESS_CHK;
                    w_cnt_nxt   = 16'd1;
                end
            end
            ST_PRESS_CHK: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = ST_PRESSED;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_PRESSED: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_RELEASE_CHK;
                    w_cnt_nxt   = 16'd1;
                end
            end
            ST_RELEASE_CHK: begin
                if (w_pressed) begin
                    w_state_nxt = ST_PRESSED;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from the transition about to be taken; registered below.
    always_comb begin
        w_press_set   = (r_state == ST_PRESS_CHK)   && (w_state_nxt == ST_PRESSED);
        w_release_set = (r_state == ST_RELEASE_CHK) && (w_state_nxt == ST_IDLE);
        w_level_nxt   = (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE_CHK);
    end

    // Registered outputs. press_count advances the cycle after press_pulse is visible, so a
    // clr presented alongside the strobe clears the old total and still counts this press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_count   <= 8'd0;
        end else begin
            r_level   <= w_level_nxt;
            r_press   <= w_press_set;
            r_release <= w_release_set;
            if (clr) begin
                r_count <= r_press ? 8'd1 : 8'd0;
            end else if (r_press) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign press_count   = r_count;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    localparam logic [23:0] LONG_LAST = 24'(LONG_CYCLES);

    logic [23:0] r_hold;
    logic        r_long;
    logic        w_holding;

    assign w_holding = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_CHK);

    // Hold timer restarts only on a fresh press; a release bounce back to PRESSED keeps
    // timing the same press, so long_pulse fires at most once per press. Saturates at LONG_LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= 24'd0;
            r_long <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (w_press_set) begin
                r_hold <= 24'd0;
            end else if (w_holding && (r_hold != LONG_LAST)) begin
                r_hold <= r_hold + 24'd1;
                r_long <= ((r_hold + 24'd1) == LONG_LAST);
            end
        end
    end

    assign long_pulse = r_long;
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 200, consecutive stable synchronized samples needed to accept a level change (20 ms at 10 kHz low-frequency clock); legal range 1..65535.
REQ-002 Parameter: LONG_CYCLES, 10000, cycles a debounced press must be held to report a long press (1 s at 10 kHz); legal range 1..2^24-1.
REQ-003 Port: clk  input  1  single clock for all logic.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: btn_n  input  1  raw pushbutton; asynchronous to clk; 0 = pressed.
REQ-006 Port: clr  input  1  synchronous clear of press_count.
REQ-007 Port: btn_level  output  1  debounced level; 1 = pressed.
REQ-008 Port: press_pulse  output  1  one-cycle strobe when a press is accepted.
REQ-009 Port: release_pulse  output  1  one-cycle strobe when a release is accepted.
REQ-010 Port: long_pulse  output  1  one-cycle strobe on long press.
REQ-011 Port: press_count  output  8  number of accepted presses, modulo 256.

Function
REQ-012 btn_n SHALL pass through a 2-flop synchronizer; its output s (pressed = ~sync) is the only value the FSM samples.
REQ-013 FSM SHALL have four states: IDLE (released), PRESS_CHK, PRESSED, RELEASE_CHK.
REQ-014 IDLE: s pressed -> PRESS_CHK, stability counter = 1; otherwise stay.
REQ-015 PRESS_CHK: s pressed and counter == DEBOUNCE_CYCLES -> PRESSED; s pressed otherwise -> counter+1; s released -> IDLE, counter cleared.
REQ-016 PRESSED/RELEASE_CHK SHALL mirror REQ-014/015 with the levels swapped, ending in IDLE.
REQ-017 With btn_n low and stable from before edge 0, press_pulse SHALL be registered high at edge DEBOUNCE_CYCLES+2 and low at the next edge.
REQ-018 btn_level SHALL be 1 exactly while in PRESSED or RELEASE_CHK; all outputs registered, no combinational path from btn_n.
REQ-019 press_pulse SHALL assert only on PRESS_CHK->PRESSED; release_pulse only on RELEASE_CHK->IDLE; never both in one cycle.
REQ-020 Any bounce shorter than DEBOUNCE_CYCLES samples SHALL produce no pulse and no btn_level change.
REQ-021 press_count SHALL increment on press_pulse and wrap 255 -> 0.
REQ-022 clr SHALL zero press_count; clr coincident with press_pulse SHALL yield press_count = 1.
REQ-023 Stability counter SHALL be 16 bits and SHALL never wrap while in a CHK state.

Reset
REQ-024 rst SHALL asynchronously force FSM to IDLE, counters to 0, synchronizer flops to 1 (released), all outputs to 0.
REQ-025 Reset mid-debounce or mid-press SHALL discard progress with no pulse; no release_pulse is generated for a press in progress.
REQ-026 Button held through reset release SHALL be accepted as a new press DEBOUNCE_CYCLES+2 cycles after rst deasserts.

Configuration
REQ-027 Macro BUTTON_DEBOUNCE_LONGPRESS_EN defined: a 24-bit hold counter SHALL clear on entering PRESSED, count cycles in PRESSED and RELEASE_CHK, and fire long_pulse for one cycle when it reaches LONG_CYCLES, at most once per press, saturating afterwards.
REQ-028 Macro undefined: long_pulse SHALL be constant 0 and no hold counter SHALL be synthesized; all other behaviour identical.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-029 btn_n 1->0 held -> press_pulse high only in cycle after edge 6, btn_level 1 from edge 6, press_count 0->1.
REQ-030 btn_n low 3 cycles then high, repeated 5x -> no pulses, btn_level stays 0, press_count stays 0.
REQ-031 Accepted press, then btn_n high held -> release_pulse one cycle at edge 6 after the rise, btn_level 0.
REQ-032 256 clean presses -> press_count wraps to 0; clr asserted with 257th press_pulse -> press_count = 1.
REQ-033 rst pulsed mid PRESS_CHK and mid PRESSED with btn_n low -> outputs 0 immediately, no release_pulse, press_pulse 6 cycles after rst release.
REQ-034 With macro defined, btn_n low 30 cycles -> long_pulse once, 20 cycles after press_pulse; with macro undefined -> long_pulse never high.
